instr_encoder: RTL and testbench

- Producer side of the 9-bit instruction format consumed by the core's instruction decoder.
- Accepts symbolic instructions (mnemonic, register indices, immediate) over a valid/ready stream.
- Checks each field against the register window the format permits, packs it into a 9-bit word, and writes it sequentially into instruction memory.
- Used for program loading in simulation/FPGA bring-up; stops at HALT or when memory is full.

---
 rtl/instr_pkg.sv | 68 ++++++
 rtl/instr_pack.sv | 108 ++++++++++
 rtl/instr_encoder.sv | 163 ++++++++++++++++
 tb/tb_instr_encoder.sv | 228 ++++++++++++++++++++++
 4 files changed

// File: rtl/instr_pkg.sv
// Shared definitions for the 9-bit instruction format: mnemonics, opcode and
// subop field values, register window bases and encoder FSM states.
package instr_pkg;

    localparam int INSTR_W = 9;

    typedef enum logic [3:0] {
        OP_AND  = 4'd0,
        OP_SLT  = 4'd1,
        OP_OR   = 4'd2,
        OP_JR   = 4'd3,
        OP_LW   = 4'd4,
        OP_SW   = 4'd5,
        OP_ADD  = 4'd6,
        OP_ADDI = 4'd7,
        OP_SUB  = 4'd8,
        OP_TR   = 4'd9,
        OP_BEQ  = 4'd10,
        OP_SRL  = 4'd11,
        OP_SRA  = 4'd12,
        OP_SLL  = 4'd13,
        OP_HALT = 4'd14
    } op_code_e;

    // Major opcodes, bits [8:6]
    localparam logic [2:0] OPC_ALU   = 3'b000;
    localparam logic [2:0] OPC_MEM   = 3'b001;
    localparam logic [2:0] OPC_ADD   = 3'b010;
    localparam logic [2:0] OPC_ADDI  = 3'b011;
    localparam logic [2:0] OPC_SUB   = 3'b100;
    localparam logic [2:0] OPC_TR    = 3'b101;
    localparam logic [2:0] OPC_BEQ   = 3'b110;
    localparam logic [2:0] OPC_SHIFT = 3'b111;

    // Subop values, bits [1:0]
    localparam logic [1:0] SUB_AND  = 2'b00;
    localparam logic [1:0] SUB_SLT  = 2'b01;
    localparam logic [1:0] SUB_OR   = 2'b10;
    localparam logic [1:0] SUB_JR   = 2'b11;
    localparam logic [1:0] SUB_LW   = 2'b00;
    localparam logic [1:0] SUB_SW   = 2'b01;
    localparam logic [1:0] SUB_SRL  = 2'b00;
    localparam logic [1:0] SUB_SRA  = 2'b01;
    localparam logic [1:0] SUB_SLL  = 2'b10;
    localparam logic [1:0] SUB_ZERO = 2'b00;

    // Register window bases; each field stores index minus its base
    localparam logic [3:0] BASE_HI     = 4'd4;
    localparam logic [3:0] BASE_C      = 4'd8;
    localparam logic [3:0] BASE_TR_DST = 4'd1;
    localparam logic [3:0] BASE_TR_SRC = 4'd5;

    localparam logic [8:0] HALT_WORD = 9'h1C3;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_LOAD = 2'd1,
        ST_DONE = 2'd2,
        ST_FULL = 2'd3
    } enc_state_e;

    // True when idx lies in [base, base+span)
    function automatic logic in_window(input logic [7:0] idx, input logic [7:0] base,
                                       input logic [7:0] span);
        return (idx >= base) && (idx < (base + span));
    endfunction

endpackage

// File: rtl/instr_pack.sv
// Combinational packer: symbolic op fields to 9-bit word plus legality flag.
// Also used by the decoder bench to produce golden words.
module instr_pack
    import instr_pkg::*;
#(
    parameter int reg_w = 4
) (
    input  logic [3:0]       op_code,
    input  logic [reg_w-1:0] ra,
    input  logic [reg_w-1:0] rb,
    input  logic [reg_w-1:0] rc,
    input  logic [1:0]       imm,
    output logic [8:0]       word,
    output logic             legal
);

    logic ra_hi_ok_s;
    logic ra_lo_ok_s;
    logic rb_lo_ok_s;
    logic rb_c_ok_s;
    logic rc_c_ok_s;
    logic tr_dst_ok_s;
    logic tr_src_ok_s;

    // Window membership of each register field
    always_comb begin
        ra_hi_ok_s  = in_window(8'(ra), 8'(BASE_HI), 8'd4);
        ra_lo_ok_s  = in_window(8'(ra), 8'd0, 8'd4);
        rb_lo_ok_s  = in_window(8'(rb), 8'd0, 8'd4);
        rb_c_ok_s   = in_window(8'(rb), 8'(BASE_C), 8'd4);
        rc_c_ok_s   = in_window(8'(rc), 8'(BASE_C), 8'd4);
        tr_dst_ok_s = in_window(8'(ra), 8'(BASE_TR_DST), 8'd8);
        tr_src_ok_s = in_window(8'(rb), 8'(BASE_TR_SRC), 8'd7);
    end

    // Field packing per mnemonic; unused operands never affect legality
    always_comb begin
        word  = 9'd0;
        legal = 1'b0;
        case (op_code)
            OP_AND: begin
                word  = {OPC_ALU, 2'(ra - BASE_HI), 2'(rb), SUB_AND};
                legal = ra_hi_ok_s & rb_lo_ok_s;
            end
            OP_SLT: begin
                word  = {OPC_ALU, 2'(ra - BASE_HI), 2'(rb - BASE_C), SUB_SLT};
                legal = ra_hi_ok_s & rb_c_ok_s;
            end
            OP_OR: begin
                word  = {OPC_ALU, 2'(ra - BASE_HI), 2'(rb), SUB_OR};
                legal = ra_hi_ok_s & rb_lo_ok_s;
            end
            OP_JR: begin
                word  = {OPC_ALU, 2'(ra - BASE_HI), 2'(rb), SUB_JR};
                legal = ra_hi_ok_s & rb_lo_ok_s;
            end
            OP_LW: begin
                word  = {OPC_MEM, 2'(ra - BASE_HI), 2'(rb), SUB_LW};
                legal = ra_hi_ok_s & rb_lo_ok_s;
            end
            OP_SW: begin
                word  = {OPC_MEM, 2'(ra - BASE_HI), 2'(rb), SUB_SW};
                legal = ra_hi_ok_s & rb_lo_ok_s;
            end
            OP_ADD: begin
                word  = {OPC_ADD, 2'(ra - BASE_HI), 2'(rb), 2'(rc - BASE_C)};
                legal = ra_hi_ok_s & rb_lo_ok_s & rc_c_ok_s;
            end
            OP_ADDI: begin
                word  = {OPC_ADDI, 2'(ra), 2'(rb), imm};
                legal = ra_lo_ok_s & rb_lo_ok_s;
            end
            OP_SUB: begin
                word  = {OPC_SUB, 2'(ra - BASE_HI), 2'(rb), 2'(rc - BASE_C)};
                legal = ra_hi_ok_s & rb_lo_ok_s & rc_c_ok_s;
            end
            OP_TR: begin
                word  = {OPC_TR, 3'(ra - BASE_TR_DST), 3'(rb - BASE_TR_SRC)};
                legal = tr_dst_ok_s & tr_src_ok_s;
            end
            OP_BEQ: begin
                word  = {OPC_BEQ, 2'(ra - BASE_HI), 2'(rb), SUB_ZERO};
                legal = ra_hi_ok_s & rb_lo_ok_s;
            end
            OP_SRL: begin
                word  = {OPC_SHIFT, 2'(ra - BASE_HI), 2'(rb), SUB_SRL};
                legal = ra_hi_ok_s & rb_lo_ok_s;
            end
            OP_SRA: begin
                word  = {OPC_SHIFT, 2'(ra - BASE_HI), 2'(rb), SUB_SRA};
                legal = ra_hi_ok_s & rb_lo_ok_s;
            end
            OP_SLL: begin
                word  = {OPC_SHIFT, 2'(ra - BASE_HI), 2'(rb), SUB_SLL};
                legal = ra_hi_ok_s & rb_lo_ok_s;
            end
            OP_HALT: begin
                word  = HALT_WORD;
                legal = 1'b1;
            end
            default: begin
                word  = 9'd0;
                legal = 1'b0;
            end
        endcase
    end

endmodule

// File: rtl/instr_encoder.sv
// Program loader: accepts symbolic ops on a valid/ready stream, packs legal
// ones and writes them to sequential instruction memory addresses until HALT
// or until the memory is full.
module instr_encoder
    import instr_pkg::*;
#(
    parameter int num_regs    = 12,
    parameter int instr_width = 9,
    parameter int imem_depth  = 256
) (
    input  logic                          clk,
    input  logic                          reset,
    input  logic                          start,
    input  logic                          op_valid,
    output logic                          op_ready,
    input  logic [3:0]                    op_code,
    input  logic [$clog2(num_regs)-1:0]   op_ra,
    input  logic [$clog2(num_regs)-1:0]   op_rb,
    input  logic [$clog2(num_regs)-1:0]   op_rc,
    input  logic [1:0]                    op_imm,
    output logic                          imem_we,
    output logic [$clog2(imem_depth)-1:0] imem_addr,
    output logic [instr_width-1:0]        imem_wdata,
    output logic                          busy,
    output logic                          done,
    output logic                          overflow,
    output logic                          illegal,
    output logic [$clog2(imem_depth):0]   count
);

    localparam int reg_w  = $clog2(num_regs);
    localparam int addr_w = $clog2(imem_depth);
    localparam int cnt_w  = addr_w + 1;

    enc_state_e        state_r;
    enc_state_e        state_next_s;
    logic [addr_w-1:0] addr_r;
    logic [8:0]        word_s;
    logic              legal_s;
    logic              accept_s;
    logic              write_s;
    logic              restart_s;
    logic              last_addr_s;
    logic              ready_next_s;
    logic              busy_next_s;
    logic              done_next_s;
    logic              overflow_next_s;

    instr_pack #(
        .reg_w (reg_w)
    ) u_pack (
        .op_code (op_code),
        .ra      (op_ra),
        .rb      (op_rb),
        .rc      (op_rc),
        .imm     (op_imm),
        .word    (word_s),
        .legal   (legal_s)
    );

    // Handshake qualifiers; op_ready is registered and high only in LOAD
    always_comb begin
        accept_s    = op_valid & op_ready;
        write_s     = accept_s & legal_s;
        restart_s   = start & (state_r != ST_LOAD);
        last_addr_s = (addr_r == addr_w'(imem_depth - 1));
    end

    // Next-state decision
    always_comb begin
        state_next_s = state_r;
        case (state_r)
            ST_IDLE, ST_DONE, ST_FULL: begin
                if (start) begin
                    state_next_s = ST_LOAD;
                end else begin
                    state_next_s = state_r;
                end
            end
            ST_LOAD: begin
                if (write_s && (op_code == OP_HALT)) begin
                    state_next_s = ST_DONE;
                end else if (write_s && last_addr_s) begin
                    state_next_s = ST_FULL;
                end else begin
                    state_next_s = ST_LOAD;
                end
            end
            default: state_next_s = ST_IDLE;
        endcase
    end

    // Status decode of the upcoming state so the status outputs are flops
    always_comb begin
        ready_next_s    = 1'b0;
        busy_next_s     = 1'b0;
        done_next_s     = 1'b0;
        overflow_next_s = 1'b0;
        case (state_next_s)
            ST_IDLE: begin
                ready_next_s = 1'b0;
            end
            ST_LOAD: begin
                ready_next_s = 1'b1;
                busy_next_s  = 1'b1;
            end
            ST_DONE: begin
                done_next_s = 1'b1;
            end
            ST_FULL: begin
                overflow_next_s = 1'b1;
            end
            default: begin
                ready_next_s = 1'b0;
            end
        endcase
    end

    // State register with registered status outputs
    always_ff @(posedge clk) begin
        if (reset) begin
            state_r  <= ST_IDLE;
            op_ready <= 1'b0;
            busy     <= 1'b0;
            done     <= 1'b0;
            overflow <= 1'b0;
        end else begin
            state_r  <= state_next_s;
            op_ready <= ready_next_s;
            busy     <= busy_next_s;
            done     <= done_next_s;
            overflow <= overflow_next_s;
        end
    end

    // Address counter, word count and registered memory write port
    always_ff @(posedge clk) begin
        if (reset) begin
            addr_r     <= '0;
            count      <= '0;
            imem_we    <= 1'b0;
            imem_addr  <= '0;
            imem_wdata <= '0;
            illegal    <= 1'b0;
        end else begin
            imem_we <= write_s;
            illegal <= accept_s & ~legal_s;
            if (write_s) begin
                imem_addr  <= addr_r;
                imem_wdata <= instr_width'(word_s);
                addr_r     <= addr_r + addr_w'(1);
                count      <= count + cnt_w'(1);
            end else if (restart_s) begin
                addr_r <= '0;
                count  <= '0;
            end else begin
                addr_r <= addr_r;
                count  <= count;
            end
        end
    end

endmodule

// File: tb/tb_instr_encoder.sv
// Self-checking bench for instr_encoder: directed program-load scenarios plus
// randomized traffic against a behavioural reference model.
module tb_instr_encoder;

    localparam int DEPTH = 16;
    localparam int AW    = 4;

    logic          clk = 1'b0;
    logic          reset, start, op_valid, op_ready;
    logic [3:0]    op_code, op_ra, op_rb, op_rc;
    logic [1:0]    op_imm;
    logic          imem_we, busy, done, overflow, illegal;
    logic [AW-1:0] imem_addr;
    logic [8:0]    imem_wdata;
    logic [AW:0]   count;

    instr_encoder #(
        .num_regs    (12),
        .instr_width (9),
        .imem_depth  (DEPTH)
    ) dut (
        .clk        (clk),
        .reset      (reset),
        .start      (start),
        .op_valid   (op_valid),
        .op_ready   (op_ready),
        .op_code    (op_code),
        .op_ra      (op_ra),
        .op_rb      (op_rb),
        .op_rc      (op_rc),
        .op_imm     (op_imm),
        .imem_we    (imem_we),
        .imem_addr  (imem_addr),
        .imem_wdata (imem_wdata),
        .busy       (busy),
        .done       (done),
        .overflow   (overflow),
        .illegal    (illegal),
        .count      (count)
    );

    always #5 clk = ~clk;

    int n_vec = 0;
    int n_err = 0;

    // Reference state: mode 0 idle, 1 loading, 2 halted, 3 memory full
    int m_mode = 0, m_addr = 0, m_cnt = 0;
    int e_we = 0, e_ill = 0, e_addr = 0, e_wdata = 0;

    task automatic check(input string tag, input logic [15:0] obs, input logic [15:0] exp);
        n_vec++;
        if (obs !== exp) begin
            n_err++;
            $display("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Register windows allowed for each mnemonic; unused fields accept anything
    function automatic void windows(input int code, output int alo, output int ahi,
                                    output int blo, output int bhi,
                                    output int clo, output int chi);
        alo = 0; ahi = 15; blo = 0; bhi = 15; clo = 0; chi = 15;
        case (code)
            0, 2, 3, 4, 5, 10, 11, 12, 13: begin alo = 4; ahi = 7; blo = 0; bhi = 3; end
            1:    begin alo = 4; ahi = 7; blo = 8; bhi = 11; end
            6, 8: begin alo = 4; ahi = 7; blo = 0; bhi = 3; clo = 8; chi = 11; end
            7:    begin alo = 0; ahi = 3; blo = 0; bhi = 3; end
            9:    begin alo = 1; ahi = 8; blo = 5; bhi = 11; end
            default: ;
        endcase
    endfunction

    function automatic bit inr(input int v, input int lo, input int hi);
        return (v >= lo) && (v <= hi);
    endfunction

    // Expected word computed arithmetically from the format rules
    function automatic void ref_encode(input int code, input int ra, input int rb,
                                       input int rc, input int imm,
                                       output bit ok, output int word);
        int alo, ahi, blo, bhi, clo, chi, opc, low;
        windows(code, alo, ahi, blo, bhi, clo, chi);
        ok   = (code != 15) && inr(ra, alo, ahi) && inr(rb, blo, bhi) && inr(rc, clo, chi);
        opc  = 0;
        low  = 0;
        if (code <= 3) begin opc = 0; low = code; end
        else if (code <= 5) begin opc = 1; low = code - 4; end
        else if (code == 6) begin opc = 2; low = rc - 8; end
        else if (code == 7) begin opc = 3; low = imm; end
        else if (code == 8) begin opc = 4; low = rc - 8; end
        else if (code == 10) begin opc = 6; low = 0; end
        else if (code <= 13) begin opc = 7; low = code - 11; end
        word = opc * 64 + (ra - alo) * 16 + (rb - blo) * 4 + low;
        if (code == 9) word = 320 + (ra - 1) * 8 + (rb - 5);
        if (code == 14) word = 451;
        word = word & 511;
    endfunction

    // Apply one cycle of inputs, advance the model, compare every output
    task automatic step(input bit rst, input bit st, input bit v, input int code,
                        input int ra, input int rb, input int rc, input int imm);
        bit ok;
        int w;
        reset    = rst;
        start    = st;
        op_valid = v;
        op_code  = code[3:0];
        op_ra    = ra[3:0];
        op_rb    = rb[3:0];
        op_rc    = rc[3:0];
        op_imm   = imm[1:0];
        @(posedge clk);
        #1;
        if (rst) begin
            m_mode = 0; m_addr = 0; m_cnt = 0;
            e_we = 0; e_ill = 0; e_addr = 0; e_wdata = 0;
        end else begin
            e_we  = 0;
            e_ill = 0;
            if (v && m_mode == 1) begin
                ref_encode(code, ra, rb, rc, imm, ok, w);
                if (ok) begin
                    e_we    = 1;
                    e_addr  = m_addr;
                    e_wdata = w;
                    m_cnt++;
                    if (code == 14) m_mode = 2;
                    else if (m_addr == DEPTH - 1) m_mode = 3;
                    m_addr = (m_addr + 1) % DEPTH;
                end else begin
                    e_ill = 1;
                end
            end else if (st && m_mode != 1) begin
                m_mode = 1; m_addr = 0; m_cnt = 0;
            end
        end
        check("imem_we",    16'(imem_we),    16'(e_we));
        check("illegal",    16'(illegal),    16'(e_ill));
        check("imem_addr",  16'(imem_addr),  16'(e_addr));
        check("imem_wdata", 16'(imem_wdata), 16'(e_wdata));
        check("count",      16'(count),      16'(m_cnt));
        check("op_ready",   16'(op_ready),   16'(m_mode == 1));
        check("busy",       16'(busy),       16'(m_mode == 1));
        check("done",       16'(done),       16'(m_mode == 2));
        check("overflow",   16'(overflow),   16'(m_mode == 3));
    endtask

    function automatic int pick(input int lo, input int hi);
        if ($urandom_range(0, 9) < 8) return int'($urandom_range(lo, hi));
        return int'($urandom_range(0, 15));
    endfunction

    initial begin
        int alo, ahi, blo, bhi, clo, chi, code;
        reset = 1'b1; start = 1'b0; op_valid = 1'b0;
        op_code = 4'd0; op_ra = 4'd0; op_rb = 4'd0; op_rc = 4'd0; op_imm = 2'd0;

        // Reset state
        step(1, 0, 0, 0, 0, 0, 0, 0);
        step(1, 0, 0, 0, 0, 0, 0, 0);
        step(0, 0, 0, 0, 0, 0, 0, 0);

        // Single ADD
        step(0, 1, 0, 0, 0, 0, 0, 0);
        step(0, 0, 1, 6, 5, 2, 9, 0);
        check("add_word", 16'(imem_wdata), 16'h099);
        check("add_count", 16'(count), 16'd1);

        // Back-to-back ADDI and TR
        step(1, 0, 0, 0, 0, 0, 0, 0);
        step(0, 1, 0, 0, 0, 0, 0, 0);
        step(0, 0, 1, 7, 3, 1, 0, 2);
        check("addi_word", 16'(imem_wdata), 16'h0F6);
        step(0, 0, 1, 9, 8, 11, 0, 0);
        check("tr_word", 16'(imem_wdata), 16'h17E);
        check("tr_addr", 16'(imem_addr), 16'd1);

        // Illegal ops: out-of-window and reserved code
        step(1, 0, 0, 0, 0, 0, 0, 0);
        step(0, 1, 0, 0, 0, 0, 0, 0);
        step(0, 0, 1, 0, 2, 0, 0, 0);
        check("ill_window", 16'(illegal), 16'd1);
        step(0, 0, 1, 15, 5, 1, 9, 0);
        check("ill_reserved", 16'(illegal), 16'd1);
        step(0, 0, 0, 0, 0, 0, 0, 0);

        // SLL then HALT, trailing op ignored
        step(0, 0, 1, 13, 4, 3, 0, 0);
        check("sll_word", 16'(imem_wdata), 16'h1CE);
        step(0, 0, 1, 14, 0, 0, 0, 0);
        check("halt_word", 16'(imem_wdata), 16'h1C3);
        step(0, 0, 1, 6, 5, 2, 9, 0);
        check("halt_done", 16'(done), 16'd1);

        // Fill memory without HALT, then restart
        step(0, 1, 0, 0, 0, 0, 0, 0);
        for (int i = 0; i < DEPTH; i++) begin
            step(0, 0, 1, 6, 4 + (i % 4), i % 4, 8 + (i % 4), 0);
        end
        check("full_ovf", 16'(overflow), 16'd1);
        step(0, 0, 1, 6, 5, 2, 9, 0);
        step(0, 1, 0, 0, 0, 0, 0, 0);
        check("restart_ovf", 16'(overflow), 16'd0);
        step(0, 0, 1, 8, 7, 3, 11, 0);
        check("restart_addr", 16'(imem_addr), 16'd0);

        // Reset right after an accept drops the write
        step(0, 0, 1, 6, 5, 2, 9, 0);
        step(1, 0, 1, 6, 5, 2, 9, 0);
        check("rst_we", 16'(imem_we), 16'd0);

        // Randomized traffic
        for (int n = 0; n < 4000; n++) begin
            code = int'($urandom_range(0, 15));
            windows(code, alo, ahi, blo, bhi, clo, chi);
            step(($urandom_range(0, 299) == 0),
                 (m_mode != 1) ? ($urandom_range(0, 3) == 0) : ($urandom_range(0, 19) == 0),
                 ($urandom_range(0, 9) < 7),
                 code, pick(alo, ahi), pick(blo, bhi), pick(clo, chi),
                 int'($urandom_range(0, 3)));
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
